bidir_port_ctrl: RTL
====================

// Module: bidir_port_ctrl
// PURPOSE
//  Half-duplex sequencer that drives the oe/out side of an N-bit tristate pad
//  cell and consumes its `in` side. It turns single-beat read/write requests on
//  a valid/ready interface into timed bus cycles, and inserts turnaround so the
//  pad and the external device never drive the bus together. Read data passes
//  through a 2-flop synchronizer before capture.
// PARAMETERS
//  N          8  bus width in bits
//  WR_CYCLES  2  cycles the bus is driven per write (>=1)
//  TA_CYCLES  1  undriven turnaround cycles after a write (>=1)
//  RD_WAIT    3  undriven cycles from read accept to capture (>=2, covers sync)
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  reset      in   1  synchronous, active-high
//  req_valid  in   1  request present
//  req_ready  out  1  block can accept a request
//  req_write  in   1  1 = write, 0 = read (sampled on accept)
//  req_data   in   N  write data (sampled on accept)
//  rsp_valid  out  1  one-cycle pulse, read data valid
//  rsp_data   out  N  captured read data, held until next capture
//  io_oe      out  N  to tristate oe, all bits identical
//  io_out     out  N  to tristate out
//  io_in      in   N  from tristate in (asynchronous to clk)
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  - Reset (sync): state=IDLE, io_oe=0, io_out=0, rsp_valid=0, rsp_data=0,
//    counter=0, sync flops=0. Reset mid-cycle drops the request and releases
//    the bus at the next edge. No partial response.
//  - All outputs are registered except req_ready (= state==IDLE) and busy.
//  - Accept = req_valid & req_ready. Requests are accepted only in IDLE.
//    req_write/req_data are latched on accept.
//  - FSM IDLE/DRIVE/TURN/RWAIT/CAPT, down-counter cnt of width clog2(max param+1):
//    IDLE : io_oe=0. On a write accept: io_out<=req_data, io_oe<=all 1,
//           cnt<=WR_CYCLES-1, go to DRIVE. On a read accept: cnt<=RD_WAIT-1,
//           go to RWAIT.
//    DRIVE: io_oe stays 1. When cnt==0: io_oe<=0, cnt<=TA_CYCLES-1, go to TURN.
//           Otherwise cnt--.
//    TURN : io_oe=0, io_out holds. When cnt==0 go to IDLE, else cnt--.
//    RWAIT: io_oe=0. When cnt==0 go to CAPT, else cnt--.
//    CAPT : rsp_data<=sync_q, rsp_valid<=1 (this edge only), go to IDLE.
//  - Timing, with accept at edge T:
//    Write: io_oe=1 for exactly WR_CYCLES cycles after T, then TA_CYCLES cycles
//    at 0. req_ready returns after WR_CYCLES+TA_CYCLES cycles.
//    Read: rsp_valid is high for the cycle after edge T+RD_WAIT+1 and carries
//    io_in as it was 2 cycles before that edge. A read occupies RD_WAIT+1 cycles.
//  - Back-to-back requests: req_valid held high is accepted on the first IDLE
//    cycle. io_oe never rises in the same cycle it fell (TURN guarantees >=1
//    idle cycle). A read accepted directly after a write's TURN is legal.
//  - rsp_valid has no backpressure. The consumer must take it in its pulse cycle.
//  - The synchronizer runs continuously, including while driving (own data
//    loops back). That value is never captured as a response.
//  - Parameter violations (WR_CYCLES<1, TA_CYCLES<1, RD_WAIT<2) stop
//    elaboration via a generate-time error.
// STRUCTURE
//  - Shared header: state encodings (IDLE=0..CAPT=4, 3-bit) and the clog2
//    function used to size cnt.
//  - One sub-module: sync2 (parameter N, clk, reset, d, q), a 2-flop
//    synchronizer with reset 0. Everything else is inline.
//  - Top-level wiring pairs this block with the tristate cell. It does not
//    instantiate the cell itself.
// TESTING
//  1 Reset: hold reset 3 cycles mid-write -> io_oe=0 and rsp_valid=0 on the
//    next edge, req_ready=1 after release.
//  2 Write 8'hA5, defaults -> io_oe=FF, io_out=A5 for 2 cycles, then io_oe=00
//    for 1 cycle, req_ready=1 at T+3.
//  3 Read with io_in=8'h3C static, defaults -> rsp_valid pulse 1 cycle at T+4,
//    rsp_data=3C, io_oe=00 throughout.
//  4 Write 8'h11 then read with req_valid held -> gap of >=1 cycle with io_oe=0
//    between the drive and read windows; rsp_data equals the external model's
//    value, not 11.
//  5 io_in changes 8'h00->8'hFF one cycle before capture -> rsp_data=00
//    (2-cycle sync lag); a change 3 cycles before capture -> FF.
//  6 Params WR_CYCLES=1, TA_CYCLES=3, RD_WAIT=2 -> 1-cycle drive, 3-cycle turn,
//    rsp_valid at T+3; random req_valid bursts never show io_oe=1 outside DRIVE.

Source files
------------

// File: rtl/bidir_port_ctrl_pkg.sv
// Shared definitions for the bidirectional port controller.
//  - state_e : FSM state encoding (IDLE=0 .. CAPT=4, 3 bits)
//  - clog2   : ceiling log2 used to size the cycle down-counter
package bidir_port_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDrive = 3'd1,
    StTurn  = 3'd2,
    StRwait = 3'd3,
    StCapt  = 3'd4
  } state_e;

  // Smallest r such that 2**r >= value; bounded so it terminates at elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((result < 31) && ((1 << result) < value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bidir_port_ctrl_sync2.sv
// Two-flop synchronizer for an N-bit asynchronous input bus.
// Ports:
//  clk   in  1  sampling clock
//  reset in  1  synchronous active-high reset, clears both stages to 0
//  d     in  N  asynchronous input
//  q     out N  synchronized output, two clk cycles behind d
module bidir_port_ctrl_sync2 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/bidir_port_ctrl.sv
// Half-duplex sequencer for the oe/out/in side of an N-bit tristate pad cell.
// Turns single-beat read/write requests into timed bus cycles with a turnaround
// after every write so the pad and the external device never drive together.
// Ports:
//  clk       in  1  clock, all state on rising edge
//  reset     in  1  synchronous active-high reset
//  req_valid in  1  request present
//  req_ready out 1  block can accept (state is IDLE)
//  req_write in  1  1 = write, 0 = read, sampled on accept
//  req_data  in  N  write data, sampled on accept
//  rsp_valid out 1  one-cycle pulse, read data valid
//  rsp_data  out N  captured read data, held until next capture
//  io_oe     out N  tristate output enables, all bits identical
//  io_out    out N  tristate output data
//  io_in     in  N  tristate input data, asynchronous to clk
//  busy      out 1  state is not IDLE
module bidir_port_ctrl
  import bidir_port_ctrl_pkg::*;
#(
  parameter int N         = 8,
  parameter int WR_CYCLES = 2,
  parameter int TA_CYCLES = 1,
  parameter int RD_WAIT   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [N-1:0] req_data,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_data,
  output logic [N-1:0] io_oe,
  output logic [N-1:0] io_out,
  input  logic [N-1:0] io_in,
  output logic         busy
);

  localparam int MaxWrTa = (WR_CYCLES > TA_CYCLES) ? WR_CYCLES : TA_CYCLES;
  localparam int MaxCyc  = (MaxWrTa > RD_WAIT) ? MaxWrTa : RD_WAIT;
  localparam int CntW    = (clog2(MaxCyc + 1) < 1) ? 1 : clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] WrLoad = CntW'(WR_CYCLES - 1);
  localparam logic [CntW-1:0] TaLoad = CntW'(TA_CYCLES - 1);
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_WAIT - 1);

  generate
    if ((WR_CYCLES < 1) || (TA_CYCLES < 1) || (RD_WAIT < 2)) begin : g_param_err
      $error("bidir_port_ctrl: need WR_CYCLES>=1, TA_CYCLES>=1, RD_WAIT>=2");
    end
  endgenerate

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_oe;
  logic            w_oe_next;
  logic [N-1:0]    r_out;
  logic [N-1:0]    w_out_next;
  logic            r_rsp_valid;
  logic            w_rsp_valid_next;
  logic [N-1:0]    r_rsp_data;
  logic [N-1:0]    w_rsp_data_next;
  logic [N-1:0]    w_sync_q;
  logic            w_accept;
  logic            w_cnt_zero;

  // Runs continuously; while driving it sees our own data, which CAPT never uses.
  bidir_port_ctrl_sync2 #(
    .N(N)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (io_in),
    .q    (w_sync_q)
  );

  assign req_ready  = (r_state == StIdle);
  assign busy       = ~req_ready;
  assign w_accept   = req_valid & req_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // State register (also holds the registered outputs).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_oe        <= 1'b0;
      r_out       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_oe        <= w_oe_next;
      r_out       <= w_out_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
    end
  end

  // Next-state and counter.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (req_write) begin
            w_state_next = StDrive;
            w_cnt_next   = WrLoad;
          end else begin
            w_state_next = StRwait;
            w_cnt_next   = RdLoad;
          end
        end
      end
      StDrive: begin
        if (w_cnt_zero) begin
          w_state_next = StTurn;
          w_cnt_next   = TaLoad;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StTurn: begin
        if (w_cnt_zero) w_state_next = StIdle;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      StRwait: begin
        if (w_cnt_zero) w_state_next = StCapt;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      StCapt: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_oe_next        = r_oe;
    w_out_next       = r_out;
    w_rsp_valid_next = 1'b0;
    w_rsp_data_next  = r_rsp_data;
    case (r_state)
      StIdle: begin
        if (w_accept && req_write) begin
          w_oe_next  = 1'b1;
          w_out_next = req_data;
        end
      end
      StDrive: begin
        if (w_cnt_zero) w_oe_next = 1'b0;
      end
      StCapt: begin
        w_rsp_valid_next = 1'b1;
        w_rsp_data_next  = w_sync_q;
      end
      default: begin
      end
    endcase
  end

  assign io_oe     = {N{r_oe}};
  assign io_out    = r_out;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
